seven_segment_source_sequencer: RTL and testbench

Parametrised display-source selector feeding the seven-segment driver. It chooses one of `NUM_SOURCES` time sources (clock, alarm, timer, …) plus its PM flag. Selection is either direct (manual) or by automatic rotation that dwells a fixed number of ticks on each enabled source. Outputs are registered on the clock edge, and an optional blink phase blanks the display while a source is being edited.

---
 rtl/seven_segment_pkg.sv | 43 ++++
 rtl/display_tick_counter.sv | 46 ++++
 rtl/seven_segment_source_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_seven_segment_source_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment source sequencer.
//   MODE_MANUAL / MODE_AUTO : values of the i_Mode input
//   MAX_SOURCES             : upper bound on the number of selectable sources
//   next_enabled()          : wrapping search for the next enabled source index
package seven_segment_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int unsigned MAX_SOURCES = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } next_src_t;

    // First enabled index strictly after cur, wrapping modulo n. When cur is the
    // only enabled source the search wraps back onto cur itself. An out-of-range
    // cur falls through to the lowest enabled index.
    function automatic next_src_t next_enabled(input logic [3:0]  cur,
                                               input logic [15:0] enable,
                                               input int unsigned n);
        next_src_t after_cur;
        next_src_t wrapped;
        after_cur = '0;
        wrapped   = '0;
        for (int unsigned j = 0; j < MAX_SOURCES; j++) begin
            if (j < n && enable[j[3:0]]) begin
                if (j > 32'(cur)) begin
                    if (!after_cur.found) begin
                        after_cur.found = 1'b1;
                        after_cur.idx   = j[3:0];
                    end
                end else if (!wrapped.found) begin
                    wrapped.found = 1'b1;
                    wrapped.idx   = j[3:0];
                end
            end
        end
        return after_cur.found ? after_cur : wrapped;
    endfunction

endpackage

// File: rtl/display_tick_counter.sv
// Tick-enabled modulo-N counter with synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear to 0, overrides tick_i
//   tick_i        : count enable
//   count_o       : current count, 0..N-1
//   wrap_o        : terminal count reached on this tick (count returns to 0)
module display_tick_counter #(
    parameter int unsigned N = 5,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            if (count_q == W'(N - 1)) begin
                count_d = '0;
                wrap_o  = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seven_segment_source_sequencer.sv
// Selects one of NUM_SOURCES BCD time sources (plus PM flag) for the
// seven-segment driver, either directly from i_Sel (MANUAL) or by rotating
// through enabled sources every DWELL_TICKS ticks (AUTO). All outputs are
// registered.
// Optional feature macro: SEVEN_SEGMENT_BLINK_EN adds a blink phase that blanks
// a source whose i_Blink bit is set; without it i_Blink is ignored.
// Ports:
//   i_Clk, i_Rst_N    clock, asynchronous active-low reset
//   i_Tick            single-cycle timebase enable
//   i_Mode            0 = MANUAL, 1 = AUTO
//   i_Sel             manual source index
//   i_Src_Time/PM     flattened source times / PM flags
//   i_Src_Enable      sources eligible for auto rotation
//   i_Blink           per-source blink request
//   o_Display_*       selected time, PM, index, blank request
//   o_Src_Change      one-cycle pulse when o_Display_Src changes
module seven_segment_source_sequencer
    import seven_segment_pkg::*;
#(
    parameter int unsigned DECIMAL_DIGITS = 4,
    parameter int unsigned NUM_SOURCES    = 3,
    parameter int unsigned DWELL_TICKS    = 5,
    parameter int unsigned BLINK_TICKS    = 1,
    localparam int unsigned SEL_W = ($clog2(NUM_SOURCES) < 1) ? 1 : $clog2(NUM_SOURCES),
    localparam int unsigned DW    = 4 * DECIMAL_DIGITS
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_N,
    input  logic                        i_Tick,
    input  logic                        i_Mode,
    input  logic [SEL_W-1:0]            i_Sel,
    input  logic [NUM_SOURCES*DW-1:0]   i_Src_Time,
    input  logic [NUM_SOURCES-1:0]      i_Src_PM,
    input  logic [NUM_SOURCES-1:0]      i_Src_Enable,
    input  logic [NUM_SOURCES-1:0]      i_Blink,
    output logic [DW-1:0]               o_Display_Time,
    output logic                        o_Display_PM,
    output logic [SEL_W-1:0]            o_Display_Src,
    output logic                        o_Display_Blank,
    output logic                        o_Src_Change
);

    localparam logic [4:0] NUM_SRC = 5'(NUM_SOURCES);
    localparam int unsigned DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    logic             mode_q;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic             auto_mode, mode_change;
    logic [15:0]      en_pad, pm_pad;
    logic [3:0]       cur_ext, sel_ext;
    logic             any_en, cur_ok;
    next_src_t        nxt;
    logic             dwell_clear, dwell_wrap;
    logic [DWELL_W-1:0] unused_dwell_count;

    logic [SEL_W-1:0] sel_idx;
    logic             sel_in_range;
    logic [DW-1:0]    time_d;
    logic             pm_d, blank_d, blink_blank;

    assign auto_mode   = (i_Mode == MODE_AUTO);
    assign mode_change = (i_Mode != mode_q);
    assign en_pad      = 16'(i_Src_Enable);
    assign pm_pad      = 16'(i_Src_PM);
    assign cur_ext     = 4'(cur_q);
    assign any_en      = |i_Src_Enable;
    assign cur_ok      = ({1'b0, cur_ext} < NUM_SRC) && en_pad[cur_ext];
    assign nxt         = next_enabled(cur_ext, en_pad, NUM_SOURCES);

    // Next-state of the rotation pointer and dwell counter control.
    always_comb begin
        cur_d       = cur_q;
        dwell_clear = 1'b0;
        if (!auto_mode) begin
            cur_d       = i_Sel;
            dwell_clear = 1'b1;
        end else if (mode_change) begin
            // Entering AUTO: start from cur with a fresh dwell; same-cycle tick is dropped.
            dwell_clear = 1'b1;
        end else if (any_en && !cur_ok) begin
            cur_d       = SEL_W'(nxt.idx);
            dwell_clear = 1'b1;
        end else if (dwell_wrap && nxt.found) begin
            cur_d = SEL_W'(nxt.idx);
        end
    end

    display_tick_counter #(
        .N(DWELL_TICKS)
    ) u_dwell (
        .clk_i   (i_Clk),
        .rst_ni  (i_Rst_N),
        .clear_i (dwell_clear),
        .tick_i  (i_Tick),
        .count_o (unused_dwell_count),
        .wrap_o  (dwell_wrap)
    );

    // MANUAL shows i_Sel on the next edge; AUTO shows the registered pointer.
    assign sel_idx      = auto_mode ? cur_q : i_Sel;
    assign sel_ext      = 4'(sel_idx);
    assign sel_in_range = ({1'b0, sel_ext} < NUM_SRC);

`ifdef SEVEN_SEGMENT_BLINK_EN
    logic        phase_off_q, phase_off_d;
    logic        src_switch, blink_wrap;
    logic [15:0] blink_pad;
    logic [(BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1)-1:0] unused_blink_count;

    // A newly displayed source restarts the blink cycle in the visible phase.
    assign src_switch = (sel_idx != o_Display_Src);
    assign blink_pad  = 16'(i_Blink);

    display_tick_counter #(
        .N(BLINK_TICKS)
    ) u_blink (
        .clk_i   (i_Clk),
        .rst_ni  (i_Rst_N),
        .clear_i (src_switch),
        .tick_i  (i_Tick),
        .count_o (unused_blink_count),
        .wrap_o  (blink_wrap)
    );

    always_comb begin
        phase_off_d = phase_off_q;
        if (src_switch) begin
            phase_off_d = 1'b0;
        end else if (blink_wrap) begin
            phase_off_d = ~phase_off_q;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            phase_off_q <= 1'b0;
        end else begin
            phase_off_q <= phase_off_d;
        end
    end

    assign blink_blank = sel_in_range && blink_pad[sel_ext] && phase_off_d;
`else
    logic unused_blink;
    assign unused_blink = ^i_Blink;
    assign blink_blank  = 1'b0;
`endif

    always_comb begin
        time_d = '0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            if (sel_ext == 4'(k)) begin
                time_d = i_Src_Time[k*DW +: DW];
            end
        end
        pm_d    = sel_in_range && pm_pad[sel_ext];
        blank_d = !sel_in_range || (auto_mode && !any_en) || blink_blank;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            mode_q          <= MODE_MANUAL;
            cur_q           <= '0;
            o_Display_Time  <= '0;
            o_Display_PM    <= 1'b0;
            o_Display_Src   <= '0;
            o_Display_Blank <= 1'b0;
            o_Src_Change    <= 1'b0;
        end else begin
            mode_q          <= i_Mode;
            cur_q           <= cur_d;
            o_Display_Time  <= time_d;
            o_Display_PM    <= pm_d;
            o_Display_Src   <= sel_idx;
            o_Display_Blank <= blank_d;
            o_Src_Change    <= (sel_idx != o_Display_Src);
        end
    end

endmodule

// File: tb/tb_seven_segment_source_sequencer.sv
// Self-checking bench for seven_segment_source_sequencer with default parameters
// (4 digits, 3 sources, dwell 5, blink 1). Blank expectations for the blink
// sequence follow SEVEN_SEGMENT_BLINK_EN.
module tb_seven_segment_source_sequencer;

`ifdef SEVEN_SEGMENT_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] s0, s1, s2;
    logic [2:0]  pm, en, blink;
    logic [47:0] src_time;
    logic [15:0] d_time;
    logic        d_pm, d_blank, d_chg;
    logic [1:0]  d_src;

    int checks = 0;
    int errors = 0;

    assign src_time = {s2, s1, s0};

    always #5 clk = ~clk;

    seven_segment_source_sequencer dut (
        .i_Clk           (clk),
        .i_Rst_N         (rst_n),
        .i_Tick          (tick),
        .i_Mode          (mode),
        .i_Sel           (sel),
        .i_Src_Time      (src_time),
        .i_Src_PM        (pm),
        .i_Src_Enable    (en),
        .i_Blink         (blink),
        .o_Display_Time  (d_time),
        .o_Display_PM    (d_pm),
        .o_Display_Src   (d_src),
        .o_Display_Blank (d_blank),
        .o_Src_Change    (d_chg)
    );

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [15:0] t1;
        logic        pm1;
        logic [15:0] et;
        logic        epm;
        logic [1:0]  esrc;
        logic        eblank;
        logic        echg;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] t, input logic p,
                           input logic [1:0] s, input logic b, input logic c);
        chk({tag, "_time"},  32'(d_time),  32'(t));
        chk({tag, "_pm"},    32'(d_pm),    32'(p));
        chk({tag, "_src"},   32'(d_src),   32'(s));
        chk({tag, "_blank"}, 32'(d_blank), 32'(b));
        chk({tag, "_chg"},   32'(d_chg),   32'(c));
    endtask

    initial begin
        vecs[0] = '{"m_sel0",  2'd0, 16'h1234, 1'b1, 16'h1111, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[1] = '{"m_sel2",  2'd2, 16'h1234, 1'b1, 16'h0959, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[2] = '{"m_hold2", 2'd2, 16'h1234, 1'b1, 16'h0959, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[3] = '{"m_oor",   2'd3, 16'h1234, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b1};
        vecs[4] = '{"m_oor2",  2'd3, 16'h1234, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0};
        vecs[5] = '{"m_sel1",  2'd1, 16'h1234, 1'b1, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[6] = '{"m_upd1",  2'd1, 16'h4321, 1'b0, 16'h4321, 1'b0, 2'd1, 1'b0, 1'b0};

        rst_n = 1'b0;
        tick  = 1'b0;
        mode  = 1'b0;
        sel   = 2'd1;
        s0 = 16'h1111; s1 = 16'h1234; s2 = 16'h0959;
        pm    = 3'b110;
        en    = 3'b000;
        blink = 3'b000;

        // Reset holds all outputs at zero.
        step();
        step();
        chk_all("reset", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("rel_sel1", 16'h1234, 1'b1, 2'd1, 1'b0, 1'b1);

        // Manual selection table (enable ignored: en stays 000).
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            s1  = vecs[i].t1;
            pm[1] = vecs[i].pm1;
            step();
            chk_all(vecs[i].name, vecs[i].et, vecs[i].epm, vecs[i].esrc,
                    vecs[i].eblank, vecs[i].echg);
        end
        s1 = 16'h1234;
        pm[1] = 1'b1;

        // Auto rotation over 3'b101 starting from 0.
        en  = 3'b101;
        sel = 2'd0;
        step();
        mode = 1'b1;
        step();
        chk("auto_enter_src", 32'(d_src), 32'd0);
        pulses(4);
        chk("auto_4t_src", 32'(d_src), 32'd0);
        pulses(1);
        chk("auto_5t_src", 32'(d_src), 32'd2);
        chk("auto_5t_chg", 32'(d_chg), 32'd1);
        chk("auto_5t_time", 32'(d_time), 32'h0959);
        chk("auto_5t_blank", 32'(d_blank), 32'd0);
        step();
        chk("auto_chg_once", 32'(d_chg), 32'd0);
        pulses(5);
        chk("auto_10t_src", 32'(d_src), 32'd0);
        chk("auto_10t_chg", 32'(d_chg), 32'd1);

        // No enabled source: hold and blank.
        en = 3'b000;
        step();
        chk("noen_blank", 32'(d_blank), 32'd1);
        pulses(5);
        chk("noen_src", 32'(d_src), 32'd0);
        chk("noen_blank2", 32'(d_blank), 32'd1);

        // Disabled current source mid-dwell.
        en = 3'b101;
        step();
        pulses(5);
        chk("dis_at2_src", 32'(d_src), 32'd2);
        pulses(2);
        en = 3'b001;
        step();
        chk("dis_edge1_src", 32'(d_src), 32'd2);
        step();
        chk("dis_edge2_src", 32'(d_src), 32'd0);
        chk("dis_edge2_chg", 32'(d_chg), 32'd1);
        en = 3'b101;
        pulses(4);
        chk("dis_restart4_src", 32'(d_src), 32'd0);
        pulses(1);
        chk("dis_restart5_src", 32'(d_src), 32'd2);

        // Tick coinciding with MANUAL->AUTO is discarded.
        mode = 1'b0;
        sel  = 2'd2;
        step();
        chk("sw_man_src", 32'(d_src), 32'd2);
        mode = 1'b1;
        pulses(1);
        pulses(4);
        chk("sw_tick_lost_src", 32'(d_src), 32'd2);
        pulses(1);
        chk("sw_adv_src", 32'(d_src), 32'd0);

        // AUTO->MANUAL takes i_Sel immediately.
        mode = 1'b0;
        sel  = 2'd1;
        step();
        chk("a2m_src", 32'(d_src), 32'd1);
        chk("a2m_chg", 32'(d_chg), 32'd1);

        // Blink sequence on source 1, then switch to source 0.
        blink = 3'b011;
        step();
        chk("blk_on", 32'(d_blank), 32'd0);
        pulses(1);
        chk("blk_t1", 32'(d_blank), 32'(BLINK_ON));
        pulses(1);
        chk("blk_t2", 32'(d_blank), 32'd0);
        pulses(1);
        chk("blk_t3", 32'(d_blank), 32'(BLINK_ON));
        sel = 2'd0;
        step();
        chk("blk_switch", 32'(d_blank), 32'd0);
        chk("blk_switch_src", 32'(d_src), 32'd0);
        pulses(1);
        chk("blk_new_t1", 32'(d_blank), 32'(BLINK_ON));
        blink = 3'b000;

        // Asynchronous reset mid-dwell, then restart.
        step();
        mode = 1'b1;
        step();
        pulses(5);
        chk("ar_at2_src", 32'(d_src), 32'd2);
        pulses(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("ar_async", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("ar_rel_src", 32'(d_src), 32'd0);
        chk("ar_rel_time", 32'(d_time), 32'h1111);
        pulses(4);
        chk("ar_4t_src", 32'(d_src), 32'd0);
        pulses(1);
        chk("ar_5t_src", 32'(d_src), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
